palindrome_window_det: RTL and testbench
========================================

Name: palindrome_window_det

Overview:
- Serial-bit palindrome detector with a runtime-selectable window length, the successor to the fixed 3-bit detector.
- Accepts one bit per cycle under a valid qualifier and keeps up to MAX_LEN-1 bits of history.
- Flags, combinationally with the current bit, when the last L accepted bits form a palindrome.
- Adds synchronous clear, length-change restart, config-error flag and a saturating match counter.

Parameters:
- MAX_LEN, 8, largest supported window length; legal range >= 2.
- CNT_W, 8, width of the match counter.
- LEN_W, $clog2(MAX_LEN+1), width of len_i (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- x_valid_i  input  1  x_i carries a bit this cycle.
- x_i  input  1  serial data bit.
- len_i  input  LEN_W  window length L; quasi-static; legal range 2..MAX_LEN.
- clear_i  input  1  synchronous restart of the window and counter.
- palindrome_o  output  1  the window ending at the current x_i is a palindrome (combinational).
- window_full_o  output  1  enough history is held that the next valid bit completes a window.
- match_cnt_o  output  CNT_W  count of palindrome_o pulses; saturating.
- cfg_err_o  output  1  len_q is outside 2..MAX_LEN.

Behaviour:
- State:
  - hist[MAX_LEN-2:0]: shift register; hist[0] is the most recent accepted bit.
  - fill_q: saturates at MAX_LEN-1.
  - len_q: LEN_W bits.
  - cnt_q: CNT_W bits.
- Reset (reset_n=0, asynchronous): hist=0, fill_q=0, len_q=0, cnt_q=0.
  - Outputs during reset: palindrome_o=0, window_full_o=0, match_cnt_o=0, cfg_err_o=1 (len_q=0).
- Window definition: w[0]=x_i, w[k]=hist[k-1] for k=1..L-1, with L=len_q.
- Palindrome condition: w[k]==w[L-1-k] for all k<L/2. For odd L the middle bit is ignored.
- palindrome_o=1 iff all of the following hold:
  - x_valid_i=1;
  - clear_i=0;
  - len_i==len_q;
  - cfg_err_o=0;
  - fill_q >= L-1;
  - the palindrome condition holds.
- Latency: zero cycles. The flag asserts in the same cycle the L-th bit is presented.
- Priority each cycle: clear_i, then length change, then normal.
- clear_i=1:
  - hist<=0, fill_q<=0, cnt_q<=0.
  - x_i is discarded; len_q<=len_i.
- Length change (len_i!=len_q, clear_i=0):
  - len_q<=len_i; fill_q<=x_valid_i ? 1 : 0.
  - If valid, x_i is shifted into hist and is the first bit of the new window.
  - palindrome_o=0 this cycle.
- Normal, x_valid_i=1:
  - hist<={hist[MAX_LEN-3:0],x_i}.
  - fill_q<=min(fill_q+1, MAX_LEN-1).
- Normal, x_valid_i=0: all state holds. Gaps between valid bits are transparent.
- cnt_q increments by 1 on every cycle palindrome_o=1 and holds at 2^CNT_W-1 (no wrap).
- window_full_o = (fill_q >= len_q-1) && !cfg_err_o && (len_i==len_q).
- Illegal length (len_q<2 or len_q>MAX_LEN):
  - cfg_err_o=1; palindrome_o forced to 0.
  - hist and fill_q still update on valid bits.
- Overlapping windows: every valid bit after fill is reached is evaluated (sliding window, stride 1).
- reset_n assertion mid-stream clears all state immediately. No window spans a reset.

Test Plan:
- Legacy length: L=3, valid bits 1,0,1,1,0,1.
  - palindrome_o = 0,0,1,0,0,1.
  - match_cnt_o ends at 2.
- Even length with gaps: L=4, bits 1,0,0,1 with x_valid_i=0 idle cycles between each.
  - palindrome_o=1 only on the 4th valid bit; 0 during idle cycles.
  - Next bit 0 gives window 0,0,1,0 -> palindrome_o=0.
- Length change: L=3, feed 1,0,1 (flag=1), then len_i=5 with bit 1.
  - palindrome_o=0 on the change cycle, fill_q=1.
  - Then 0,0,0,1: flag=1 only on the last bit (window 1,0,0,0,1).
  - window_full_o=1 after the 4th bit of the new window.
- Clear and saturation: CNT_W=2, L=2, stream of 6 valid zeros.
  - match_cnt_o = 0,1,2,3,3,3.
  - clear_i=1 with x_valid_i=1 -> palindrome_o=0, match_cnt_o=0 next cycle.
  - Next single 0 -> no flag (fill restarted).
- Config error: len_i=1 and len_i=9 (MAX_LEN=8) -> cfg_err_o=1, palindrome_o=0 for an all-zero stream.
  - Then len_i=2 -> cfg_err_o=0; first match on the 2nd new valid bit.
- Async reset: drive reset_n=0 between clock edges mid-window (L=5, 3 bits in).
  - All outputs reach their reset values immediately.
  - After release, the first palindrome_o requires 5 fresh valid bits.

Source files
------------

// File: rtl/palindrome_window_det.sv
// Serial-bit palindrome detector with a runtime-selectable window length.
// Flags a palindromic window combinationally and counts matches, saturating at the counter maximum.
module palindrome_window_det #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             x_valid_i,
  input  logic             x_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             clear_i,
  output logic             palindrome_o,
  output logic             window_full_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic             cfg_err_o
);

  localparam int unsigned HIST_W = MAX_LEN - 1;
  localparam int unsigned FILL_W = $clog2(MAX_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [HIST_W-1:0]  hist_q;
  logic [FILL_W-1:0]  fill_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [MAX_LEN-1:0] win;
  logic               sym;
  logic               fill_ok;
  logic               len_same;
  logic               cfg_err;
  logic               match;

  // win[0] is the incoming bit, win[k] the k-th most recent history bit
  assign win      = {hist_q, x_i};
  assign len_same = (len_i == len_q);
  assign cfg_err  = (len_q < LEN_W'(2)) || (len_q > LEN_W'(MAX_LEN));
  assign fill_ok  = (32'(fill_q) + 32'd1) >= 32'(len_q);

  // Mirror-pair comparison over the first L bits; middle bit of odd L is unpaired
  always_comb begin
    sym = 1'b1;
    for (int k = 0; k < int'(MAX_LEN); k++) begin
      for (int j = 0; j < int'(MAX_LEN); j++) begin
        if ((k < int'(len_q) / 2) && (j == int'(len_q) - 1 - k) && (win[k] != win[j])) begin
          sym = 1'b0;
        end
      end
    end
  end

  assign match         = x_valid_i && !clear_i && len_same && !cfg_err && fill_ok && sym;
  assign palindrome_o  = match;
  assign window_full_o = fill_ok && !cfg_err && len_same;
  assign cfg_err_o     = cfg_err;
  assign match_cnt_o   = cnt_q;

  // History, fill level, latched length and match counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      fill_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      len_q  <= len_i;
    end else if (!len_same) begin
      // New window length restarts the fill; a valid bit here opens the new window
      len_q  <= len_i;
      fill_q <= x_valid_i ? FILL_W'(1) : '0;
      if (x_valid_i) begin
        hist_q <= HIST_W'({hist_q, x_i});
      end
    end else begin
      if (x_valid_i) begin
        hist_q <= HIST_W'({hist_q, x_i});
        if (fill_q != FILL_MAX) begin
          fill_q <= fill_q + FILL_W'(1);
        end
      end
      if (match && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_palindrome_window_det.sv
// Directed bench for palindrome_window_det: a default instance plus a 2-bit-counter
// instance sharing the same stimulus for the saturation scenario.
module tb_palindrome_window_det;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk;
  logic             reset_n;
  logic             x_valid;
  logic             x;
  logic [LEN_W-1:0] len;
  logic             clear;

  logic             pal, wf, cfg_err;
  logic [7:0]       cnt;
  logic             pal_s, wf_s, cfg_err_s;
  logic [1:0]       cnt_s;

  int checks = 0;
  int errors = 0;

  int t1_bits [6] = '{1, 0, 1, 1, 0, 1};
  int t1_pal  [6] = '{0, 0, 1, 0, 0, 1};
  int t2_bits [4] = '{1, 0, 0, 1};
  int t4_cnt  [6] = '{0, 1, 2, 3, 3, 3};
  int t6_bits [5] = '{1, 0, 1, 0, 1};

  palindrome_window_det #(.MAX_LEN(MAX_LEN), .CNT_W(8)) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .x_valid_i     (x_valid),
    .x_i           (x),
    .len_i         (len),
    .clear_i       (clear),
    .palindrome_o  (pal),
    .window_full_o (wf),
    .match_cnt_o   (cnt),
    .cfg_err_o     (cfg_err)
  );

  palindrome_window_det #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_sat (
    .clk           (clk),
    .reset_n       (reset_n),
    .x_valid_i     (x_valid),
    .x_i           (x),
    .len_i         (len),
    .clear_i       (clear),
    .palindrome_o  (pal_s),
    .window_full_o (wf_s),
    .match_cnt_o   (cnt_s),
    .cfg_err_o     (cfg_err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after an edge, then settle to mid-cycle for combinational checks
  task automatic drive(input logic v, input logic b, input logic [LEN_W-1:0] l, input logic c);
    x_valid = v;
    x       = b;
    len     = l;
    clear   = c;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic v, input logic b,
                      input logic [LEN_W-1:0] l, input logic c, input logic exp_pal);
    drive(v, b, l, c);
    chk(tag, pal, exp_pal);
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    x_valid = 1'b0;
    x       = 1'b0;
    len     = '0;
    clear   = 1'b0;
    #2;
    chk("rst_pal", pal, 0);
    chk("rst_wf", wf, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_cfg_err", cfg_err, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // Legacy length 3
    step("t1_clear", 0, 0, 3, 1, 0);
    chk("t1_cfg_ok", cfg_err, 0);
    for (int i = 0; i < 6; i++) begin
      step($sformatf("t1_pal%0d", i), 1, t1_bits[i][0], 3, 0, t1_pal[i][0]);
    end
    chk("t1_cnt", cnt, 2);

    // Length 4 with idle gaps
    step("t2_clear", 0, 0, 4, 1, 0);
    chk("t2_cnt_cleared", cnt, 0);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("t2_pal%0d", i), 1, t2_bits[i][0], 4, 0, (i == 3));
      drive(0, 1, 4, 0);
      chk($sformatf("t2_idle_pal%0d", i), pal, 0);
      chk($sformatf("t2_idle_wf%0d", i), wf, (i >= 2));
      tick();
    end
    step("t2_next0", 1, 0, 4, 0, 0);
    chk("t2_cnt", cnt, 1);

    // Length change 3 -> 5
    step("t3_clear", 0, 0, 3, 1, 0);
    step("t3_b0", 1, 1, 3, 0, 0);
    step("t3_b1", 1, 0, 3, 0, 0);
    step("t3_b2", 1, 1, 3, 0, 1);
    drive(1, 1, 5, 0);
    chk("t3_chg_pal", pal, 0);
    chk("t3_chg_wf", wf, 0);
    tick();
    chk("t3_cnt_after_chg", cnt, 1);
    step("t3_n1", 1, 0, 5, 0, 0);
    step("t3_n2", 1, 0, 5, 0, 0);
    chk("t3_wf_fill3", wf, 0);
    step("t3_n3", 1, 0, 5, 0, 0);
    chk("t3_wf_fill4", wf, 1);
    step("t3_n4", 1, 1, 5, 0, 1);
    chk("t3_cnt", cnt, 2);

    // Saturating 2-bit counter, then clear
    step("t4_clear", 0, 0, 2, 1, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 2, 0);
      chk($sformatf("t4_pal%0d", i), pal_s, (i > 0));
      tick();
      chk($sformatf("t4_cnt%0d", i), cnt_s, t4_cnt[i]);
    end
    chk("t4_cnt_wide", cnt, 5);
    drive(1, 0, 2, 1);
    chk("t4_clr_pal", pal_s, 0);
    tick();
    chk("t4_clr_cnt", cnt_s, 0);
    chk("t4_clr_cnt_wide", cnt, 0);
    drive(1, 0, 2, 0);
    chk("t4_refill_pal0", pal_s, 0);
    tick();
    drive(1, 0, 2, 0);
    chk("t4_refill_pal1", pal_s, 1);
    tick();
    chk("t4_refill_cnt", cnt_s, 1);

    // Illegal lengths 1 and 9, then recovery at 2
    drive(0, 0, 1, 0);
    tick();
    chk("t5_len1_err", cfg_err, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0);
      chk($sformatf("t5_len1_pal%0d", i), pal, 0);
      chk($sformatf("t5_len1_wf%0d", i), wf, 0);
      tick();
    end
    drive(0, 0, 9, 0);
    tick();
    chk("t5_len9_err", cfg_err, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 9, 0);
      chk($sformatf("t5_len9_pal%0d", i), pal, 0);
      tick();
    end
    drive(0, 0, 2, 0);
    tick();
    chk("t5_len2_ok", cfg_err, 0);
    step("t5_first", 1, 0, 2, 0, 0);
    step("t5_second", 1, 0, 2, 0, 1);
    chk("t5_cnt", cnt, 2);

    // Asynchronous reset mid-window
    drive(0, 0, 5, 0);
    tick();
    step("t6_b0", 1, 1, 5, 0, 0);
    step("t6_b1", 1, 0, 5, 0, 0);
    step("t6_b2", 1, 1, 5, 0, 0);
    chk("t6_cnt_pre", cnt, 2);
    x_valid = 1'b1;
    x       = 1'b1;
    len     = 5;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_pal", pal, 0);
    chk("t6_rst_wf", wf, 0);
    chk("t6_rst_cnt", cnt, 0);
    chk("t6_rst_cfg", cfg_err, 1);
    tick();
    chk("t6_rst_hold_cnt", cnt, 0);
    x_valid = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      step($sformatf("t6_pal%0d", i), 1, t6_bits[i][0], 5, 0, (i == 4));
    end
    chk("t6_cnt", cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
